// File: rtl/life_engine.sv
// Game of Life generation engine: evaluates one cell per clock into a shadow
// buffer, then commits the whole grid in one cycle. Define LIFE_TORUS_EN for wrap-around edges.
module life_engine #(
  parameter int map_width  = 8,
  parameter int map_height = 8,
  parameter int gen_width  = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              load,
  input  logic [map_width*map_height-1:0]   seed_in,
  input  logic                              step,
  output logic                              busy,
  output logic                              done,
  output logic                              stable,
  output logic [gen_width-1:0]              generation,
  output logic [map_width*map_height-1:0]   state_out
);

  localparam int N  = map_width * map_height;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(map_width);
  localparam int RW = $clog2(map_height);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EVAL   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]    fsm;
  logic [IW-1:0] idx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [N-1:0]  next_grid;
  logic [3:0]    nbr_count;
  logic          next_cell;

  function automatic logic cell_at(input logic [N-1:0] grid, input int r, input int c);
    logic [N-1:0] shifted;
    shifted = grid >> (r * map_width + c);
    return shifted[0];
  endfunction

  function automatic logic [3:0] count_neighbours(input logic [N-1:0] grid,
                                                  input int r, input int c);
    logic [3:0] cnt;
    int rr;
    int cc;
    cnt = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (dr != 0 || dc != 0) begin
`ifdef LIFE_TORUS_EN
          if (rr < 0) rr = map_height - 1;
          else if (rr >= map_height) rr = 0;
          if (cc < 0) cc = map_width - 1;
          else if (cc >= map_width) cc = 0;
          cnt = cnt + {3'd0, cell_at(grid, rr, cc)};
`else
          // Off-grid neighbours are simply skipped, i.e. treated as dead.
          if (rr >= 0 && rr < map_height && cc >= 0 && cc < map_width)
            cnt = cnt + {3'd0, cell_at(grid, rr, cc)};
`endif
        end
      end
    end
    return cnt;
  endfunction

  function automatic logic life_rule(input logic [3:0] cnt, input logic alive);
    return (cnt == 4'd3) || (cnt == 4'd2 && alive);
  endfunction

  always_comb begin
    nbr_count = count_neighbours(state_out, int'(row), int'(col));
    next_cell = life_rule(nbr_count, state_out[idx]);
  end

  assign busy = (fsm != IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      fsm        <= IDLE;
      idx        <= '0;
      row        <= '0;
      col        <= '0;
      next_grid  <= '0;
      state_out  <= '0;
      generation <= '0;
      stable     <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (load) begin
            state_out  <= seed_in;
            generation <= '0;
            stable     <= 1'b0;
          end else if (step) begin
            fsm <= EVAL;
            idx <= '0;
            row <= '0;
            col <= '0;
          end
        end
        EVAL: begin
          // state_out stays frozen here; results accumulate in next_grid.
          next_grid[idx] <= next_cell;
          idx            <= idx + 1'b1;
          if (col == CW'(map_width - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
          if (idx == IW'(N - 1)) fsm <= COMMIT;
        end
        COMMIT: begin
          state_out  <= next_grid;
          stable     <= (next_grid == state_out);
          generation <= generation + 1'b1;
          done       <= 1'b1;
          fsm        <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: an 8x8 instance for patterns and handshake,
// and a 3x3 instance with a 4-bit generation counter for wrap and minimum size.
module tb_life_engine;

  localparam int N  = 64;
  localparam int N2 = 9;

  localparam logic [N-1:0] BLINK_H = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
  localparam logic [N-1:0] BLINK_V = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
  localparam logic [N-1:0] BLOCK   = (64'd1 << 9) | (64'd1 << 10) | (64'd1 << 17) | (64'd1 << 18);
  localparam logic [N-1:0] GLIDER  = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) |
                                     (64'd1 << 17) | (64'd1 << 18);
  localparam logic [N-1:0] CORNER  = (64'd1 << 54) | (64'd1 << 55) | (64'd1 << 62) | (64'd1 << 63);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, load, step;
  logic [N-1:0]  seed_in;
  logic          busy, done, stable;
  logic [15:0]   generation;
  logic [N-1:0]  state_out;

  logic          load2, step2;
  logic [N2-1:0] seed2;
  logic          busy2, done2, stable2;
  logic [3:0]    gen2;
  logic [N2-1:0] state2;

  int checks = 0;
  int errors = 0;

  life_engine #(.map_width(8), .map_height(8), .gen_width(16)) dut (
    .clock(clock), .reset(reset), .load(load), .seed_in(seed_in), .step(step),
    .busy(busy), .done(done), .stable(stable), .generation(generation),
    .state_out(state_out)
  );

  life_engine #(.map_width(3), .map_height(3), .gen_width(4)) dut_small (
    .clock(clock), .reset(reset), .load(load2), .seed_in(seed2), .step(step2),
    .busy(busy2), .done(done2), .stable(stable2), .generation(gen2),
    .state_out(state2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [N-1:0] seed);
    seed_in = seed;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Returns cycles from the step-sampling edge to done, or -1 on timeout.
  task automatic run_step(output int lat);
    step = 1'b1;
    tick();
    step = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_step2(output int lat);
    step2 = 1'b1;
    tick();
    step2 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (done2) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int bad;
    int interval;
    int busy_cnt;
    int seen;

    reset = 1'b0; load = 1'b0; step = 1'b0; seed_in = '0;
    load2 = 1'b0; step2 = 1'b0; seed2 = '0;
    repeat (3) tick();
    check("rst_state", 64'(state_out), 64'd0);
    check("rst_gen", 64'(generation), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stable", 64'(stable), 64'd0);
    reset = 1'b1;
    tick();

    // Blinker oscillation
    do_load(BLINK_H);
    check("blink_load", 64'(state_out), 64'(BLINK_H));
    run_step(lat);
    check("blink_lat", 64'(lat), 64'd65);
    check("blink_v", 64'(state_out), 64'(BLINK_V));
    check("blink_gen1", 64'(generation), 64'd1);
    check("blink_stable1", 64'(stable), 64'd0);
    tick();
    check("done_one_cycle", 64'(done), 64'd0);
    run_step(lat);
    check("blink_h", 64'(state_out), 64'(BLINK_H));
    check("blink_gen2", 64'(generation), 64'd2);

    // Still-life block
    do_load(BLOCK);
    check("block_gen0", 64'(generation), 64'd0);
    run_step(lat);
    check("block_s1", 64'(state_out), 64'(BLOCK));
    check("block_stable1", 64'(stable), 64'd1);
    check("block_gen1", 64'(generation), 64'd1);
    run_step(lat);
    check("block_s2", 64'(state_out), 64'(BLOCK));
    check("block_gen2", 64'(generation), 64'd2);

    // Glider for 32 generations
    do_load(GLIDER);
    bad = 0;
    for (int s = 0; s < 32; s++) begin
      run_step(lat);
      if (lat != 65) bad++;
    end
    check("glider_lat_bad", 64'(bad), 64'd0);
    check("glider_gen", 64'(generation), 64'd32);
`ifdef LIFE_TORUS_EN
    check("glider_state", 64'(state_out), 64'(GLIDER));
    check("glider_stable", 64'(stable), 64'd0);
`else
    check("glider_state", 64'(state_out), 64'(CORNER));
    check("glider_stable", 64'(stable), 64'd1);
`endif

    // Continuous step with a load attempted while busy
    do_load(BLINK_H);
    step = 1'b1;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    check("cont_first", 64'(lat), 64'd66);
    seed_in = '1;
    interval = -1;
    busy_cnt = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      load = (n == 10);
      if (busy) busy_cnt++;
      if (done) begin
        interval = n;
        break;
      end
    end
    step = 1'b0;
    load = 1'b0;
    check("cont_interval", 64'(interval), 64'd66);
    check("cont_busy", 64'(busy_cnt), 64'd65);
    check("cont_state", 64'(state_out), 64'(BLINK_H));
    check("cont_gen", 64'(generation), 64'd2);
    tick();
    check("cont_done_low", 64'(done), 64'd0);
    check("cont_idle", 64'(busy), 64'd0);

    // load and step together: load wins, step dropped
    seed_in = 64'd1;
    load = 1'b1;
    step = 1'b1;
    tick();
    load = 1'b0;
    step = 1'b0;
    check("ls_state", 64'(state_out), 64'd1);
    check("ls_gen", 64'(generation), 64'd0);
    check("ls_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (busy || done) seen++;
    end
    check("ls_no_activity", 64'(seen), 64'd0);

    // Reset during EVAL
    do_load(BLINK_H);
    run_step(lat);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (30) tick();
    check("abort_busy_pre", 64'(busy), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_state", 64'(state_out), 64'd0);
    check("abort_gen", 64'(generation), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    seen = 0;
    for (int n = 0; n < 70; n++) begin
      tick();
      if (done || busy) seen++;
    end
    check("abort_no_commit", 64'(seen), 64'd0);
    do_load(BLINK_H);
    run_step(lat);
    check("post_abort_lat", 64'(lat), 64'd65);
    check("post_abort_state", 64'(state_out), 64'(BLINK_V));
    check("post_abort_gen", 64'(generation), 64'd1);

    // 3x3 instance: all-zero grid and generation wrap
    bad = 0;
    for (int s = 0; s < 15; s++) begin
      run_step2(lat);
      if (lat != 10) bad++;
    end
    check("small_lat_bad", 64'(bad), 64'd0);
    check("small_gen15", 64'(gen2), 64'd15);
    check("small_zero", 64'(state2), 64'd0);
    check("small_stable", 64'(stable2), 64'd1);
    run_step2(lat);
    check("small_wrap", 64'(gen2), 64'd0);
    check("small_zero_wrap", 64'(state2), 64'd0);

    // 3x3 edge behaviour with a blinker across the middle row
    seed2 = 9'b000_111_000;
    load2 = 1'b1;
    tick();
    load2 = 1'b0;
    run_step2(lat);
`ifdef LIFE_TORUS_EN
    check("small_blink", 64'(state2), 64'h1FF);
`else
    check("small_blink", 64'(state2), 64'(9'b010_010_010));
`endif
    check("small_blink_gen", 64'(gen2), 64'd1);
    check("small_blink_stable", 64'(stable2), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
